// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      done_rd_addr
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [4:0] rd_q, rd_d, done_rd_q, done_rd_d;
  logic [XLEN-1:0] dv_q, dv_d, res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_p_q, neg_p_d, neg_r_q, neg_r_d, done_q, done_d;
  logic is_div, sa, sb, neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, quo, rem, fix_res;
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  assign is_div   = funct3[2];
  assign sa       = (funct3 == 3'b001) || (funct3 == 3'b010) || (is_div && !funct3[0]);
  assign sb       = (funct3 == 3'b001) || (is_div && !funct3[0]);
  assign neg_a    = sa & op_a[XLEN-1];
  assign neg_b    = sb & op_b[XLEN-1];
  assign abs_a    = neg_a ? -op_a : op_a;
  assign abs_b    = neg_b ? -op_b : op_b;
  assign div_zero = is_div && (op_b == '0);
  assign ovf      = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign spec_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  // Multiply: upper half accumulates, multiplier bits shift out of the lower half
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dv_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, dv_q};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign prod_fix = neg_p_q ? -acc_q : acc_q;
  assign quo      = neg_p_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem      = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res  = f3_q[2] ? (f3_q[1] ? rem : quo)
                            : (f3_q[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    dv_d      = dv_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_p_d   = neg_p_q;
    neg_r_d   = neg_r_q;
    res_d     = res_q;
    done_rd_d = done_rd_q;
    done_d    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        f3_d    = funct3;
        rd_d    = rd_addr;
        neg_p_d = neg_a ^ neg_b;
        neg_r_d = neg_a;
        cnt_d   = '0;
        if (div_zero || ovf) begin
          state_d   = DONE;
          done_d    = 1'b1;
          res_d     = spec_res;
          done_rd_d = rd_addr;
        end else begin
          state_d = CALC;
          dv_d    = is_div ? abs_b : abs_a;
          acc_d   = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
        end
      end
    end else if (state_q == CALC) begin
      acc_d = f3_q[2] ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_W'(XLEN-1)) ? FIX : CALC;
    end else if (state_q == FIX) begin
      res_d     = fix_res;
      done_rd_d = rd_q;
      done_d    = 1'b1;
      state_d   = DONE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      rd_q      <= '0;
      dv_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_p_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      res_q     <= '0;
      done_rd_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      dv_q      <= dv_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_p_q   <= neg_p_d;
      neg_r_q   <= neg_r_d;
      res_q     <= res_d;
      done_rd_q <= done_rd_d;
      done_q    <= done_d;
    end
  end
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result       = res_q;
  assign done_rd_addr = done_rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at XLEN=32 and XLEN=16
module tb_muldiv_unit;
  logic clk = 0, rst = 0, flush = 0, s32 = 0, s16 = 0;
  logic [2:0] funct3 = '0;
  logic [4:0] rd_addr = '0, drd32, drd16;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic busy32, done32, busy16, done16;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .start(s32), .funct3(funct3), .op_a(a32),
    .op_b(b32), .rd_addr(rd_addr), .flush(flush), .busy(busy32), .done(done32), .result(res32),
    .done_rd_addr(drd32));
  muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .start(s16), .funct3(funct3), .op_a(a16),
    .op_b(b16), .rd_addr(rd_addr), .flush(flush), .busy(busy16), .done(done16), .result(res16),
    .done_rd_addr(drd16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input bit n16, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    funct3 = f;
    rd_addr = rd;
    if (n16) begin a16 = a[15:0]; b16 = b[15:0]; s16 = 1; end
    else begin a32 = a; b32 = b; s32 = 1; end
    @(posedge clk); #1;
    s32 = 0; s16 = 0; n = 1;
    while (!(n16 ? done16 : done32) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " res"}, n16 ? {48'd0, res16} : {32'd0, res32}, exp);
    chk({tag, " rd"}, n16 ? drd16 : drd32, rd);
    @(posedge clk); #1;
    chk({tag, " pulse"}, n16 ? done16 : done32, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy32, 0);
    chk("rst done", done32, 0);
    chk("rst result", res32, 0);
    chk("rst rd", drd32, 0);
    @(negedge clk) rst = 1;

    op("mul neg", 0, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 34);

    @(negedge clk);
    funct3 = 3'b000; a32 = 3; b32 = 4; rd_addr = 5'd2; s32 = 1;
    @(posedge clk); #1 s32 = 0;
    repeat (4) @(posedge clk);
    #1 chk("pre-rst busy", busy32, 1);
    #2 rst = 0;
    #1;
    chk("midrst busy", busy32, 0);
    chk("midrst done", done32, 0);
    chk("midrst result", res32, 0);
    chk("midrst rd", drd32, 0);
    @(negedge clk) rst = 1;

    op("mul 3x4", 0, 3'b000, 32'd3, 32'd4, 5'd4, 32'd12, 34);
    op("mulh", 0, 3'b001, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000, 34);
    op("mulhu", 0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 34);
    op("mulhsu", 0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, 34);
    op("div neg", 0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 34);
    op("rem neg", 0, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 34);
    op("divu", 0, 3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 34);
    op("remu", 0, 3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 34);

    @(negedge clk);
    funct3 = 3'b000; a32 = 123; b32 = 456; rd_addr = 5'd12; s32 = 1;
    @(posedge clk); #1 s32 = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush busy", busy32, 0);
    chk("flush done", done32, 0);
    chk("flush result", res32, 2);
    chk("flush rd", drd32, 11);
    op("divu after flush", 0, 3'b101, 32'd9, 32'd3, 5'd13, 32'd3, 34);

    op("divu by0", 0, 3'b101, 32'd100, 32'd0, 5'd14, 32'hFFFFFFFF, 1);
    op("rem by0", 0, 3'b110, 32'd100, 32'd0, 5'd15, 32'd100, 1);
    op("div ovf", 0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    op("rem ovf", 0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1);

    @(negedge clk);
    funct3 = 3'b000; a32 = 5; b32 = 6; rd_addr = 5'd5; s32 = 1;
    @(posedge clk); #1 s32 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    funct3 = 3'b101; a32 = 50; b32 = 0; rd_addr = 5'd9; s32 = 1;
    @(posedge clk); #1 s32 = 0;
    n = 5;
    while (!done32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy-ign lat", n, 34);
    chk("busy-ign res", res32, 30);
    chk("busy-ign rd", drd32, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("busy-ign idle", busy32, 0);
    chk("busy-ign nodone", done32, 0);

    op("16 mul neg", 1, 3'b000, 32'd7, 32'hFFFD, 5'd20, 32'hFFEB, 18);
    op("16 mulh", 1, 3'b001, 32'h8000, 32'h8000, 5'd21, 32'h4000, 18);
    op("16 mulhu", 1, 3'b011, 32'hFFFF, 32'hFFFF, 5'd22, 32'hFFFE, 18);
    op("16 div neg", 1, 3'b100, 32'hFFF9, 32'd2, 5'd23, 32'hFFFD, 18);
    op("16 rem neg", 1, 3'b110, 32'hFFF9, 32'd2, 5'd24, 32'hFFFF, 18);
    op("16 divu", 1, 3'b101, 32'd100, 32'd7, 5'd25, 32'd14, 18);
    op("16 remu", 1, 3'b111, 32'd100, 32'd7, 5'd26, 32'd2, 18);
    op("16 divu by0", 1, 3'b101, 32'd100, 32'd0, 5'd27, 32'hFFFF, 1);
    op("16 div ovf", 1, 3'b100, 32'h8000, 32'hFFFF, 5'd28, 32'h8000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit with a parametrised datapath width.
- Sits beside the ALU in the EXE stage of the 5-stage pipeline core.
- Accepts one operation per start pulse, raises busy so the hazard logic stalls PC/IFID/IDEXE, and returns a one-cycle done pulse with result and destination register.
- Supports a flush input so a taken branch in EXE can abort an in-flight operation.

Parameters:
XLEN, 32, operand/result width in bits; legal values 8..64, even.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when state is IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (already forwarded)
op_b  input  XLEN  rs2 operand (already forwarded)
rd_addr  input  5  destination register of the request
flush  input  1  synchronous abort
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
result  output  XLEN  registered result, held until the next completion
done_rd_addr  output  5  destination register of the completed op, held with result

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0, done=0, result=0, done_rd_addr=0; counter and internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and flush=0, latch funct3, rd_addr, and the operand magnitudes plus sign flags.
  - Signed ops take absolute values; MULHSU treats op_b as unsigned.
  - Special division cases go straight to DONE. All other ops go to CALC with counter=0.
- Special division cases (accepted edge to DONE, so done appears 1 cycle after acceptance):
  - op_b==0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (op_a = most-negative, op_b = all-ones) for DIV: result = op_a. For REM: result = 0.
- CALC: one iteration per cycle, XLEN iterations, counter increments.
  - Multiply: radix-2 shift-add into a 2*XLEN product register.
  - Divide: restoring division, one quotient bit per cycle.
  - After iteration XLEN-1, go to FIX.
- FIX: one cycle.
  - Apply sign correction. Negate the product if the operand signs differ (MULHSU: sign of op_a only). Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
  - Select MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN].
  - Register result and done_rd_addr. Go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. start is ignored in DONE.
- Latency (acceptance edge to done cycle): XLEN+2 cycles for normal ops (34 at XLEN=32); 1 cycle for special cases.
- busy = (state != IDLE). A start while busy is ignored, with no queuing.
- flush:
  - Highest priority. In any state, the next edge goes to IDLE, done stays 0, and result/done_rd_addr keep their previous values.
  - flush together with start in IDLE means the request is dropped.
- Reset asserted mid-operation returns immediately to the reset values; no done is produced.
- All arithmetic is modulo 2^XLEN. Negation uses two's complement at XLEN width, or 2*XLEN for the product.

Test Plan:
- Reset mid-CALC (rst low at cycle 5) -> busy=0, done=0, result=0 immediately; after release, MUL 3*4 -> result=12, done exactly 34 cycles after acceptance.
- MUL op_a=7, op_b=0xFFFFFFFD -> result=0xFFFFFFEB; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; done_rd_addr equals the latched rd_addr in each case.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, each done 1 cycle after acceptance; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL, pulse flush at cycle 10 of CALC -> busy low next cycle, no done, result unchanged; new DIVU 9/3 on the following cycle -> 3 after 34 cycles.
- Second start (different rd_addr) while busy -> ignored, only the first completes. Repeat the MUL/DIV vectors at XLEN=16 -> correct 16-bit results, latency 18.
